// File: rtl/seg_scan_hex.sv
// Time-multiplexed hex 7-segment scanner with frame-boundary double buffering.
// Optional leading-zero suppression when SEG_SCAN_LZ_EN is defined.
module seg_scan_hex #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_mask,
  input  logic [DIGITS-1:0]   blank_mask,
  output logic [7:0]          seg_out,
  output logic [DIGITS-1:0]   an_out,
  output logic                frame_done,
  output logic                pending
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]         div_cnt_q, div_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]     pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  fd_arm_q, fd_arm_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick, boundary;
  logic [7:0]            digit_seg [DIGITS];
  logic [DIGITS-1:0]     lz_dark;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0: code = 8'hFC;  4'h1: code = 8'h60;  4'h2: code = 8'hDA;  4'h3: code = 8'hF2;
      4'h4: code = 8'h66;  4'h5: code = 8'hB6;  4'h6: code = 8'hBE;  4'h7: code = 8'hE0;
      4'h8: code = 8'hFE;  4'h9: code = 8'hE6;  4'hA: code = 8'hEE;  4'hB: code = 8'h3E;
      4'hC: code = 8'h9C;  4'hD: code = 8'h7A;  4'hE: code = 8'h9E;  default: code = 8'h8E;
    endcase
    return code[7:1];
  endfunction

  // Per-digit segment pattern from the committed buffer; blank wins over everything.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
`ifdef SEG_SCAN_LZ_EN
    if (gi == 0) begin : g_lz0
      assign lz_dark[gi] = 1'b0;
    end else begin : g_lzn
      assign lz_dark[gi] = ~|disp_val_q[4*DIGITS-1:4*gi];
    end
`else
    assign lz_dark[gi] = 1'b0;
`endif
    assign digit_seg[gi] = disp_blank_q[gi] ? 8'h00 :
                           {(lz_dark[gi] ? 7'h00 : hex_decode(disp_val_q[4*gi +: 4])), disp_dp_q[gi]};
  end

  always_comb begin
    tick     = en && (div_cnt_q == CW'(SCAN_DIV - 1));
    boundary = tick && (idx_q == IW'(DIGITS - 1));

    div_cnt_d = div_cnt_q;
    idx_d     = idx_q;
    if (tick) begin
      div_cnt_d = '0;
      idx_d     = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end else if (en) begin
      div_cnt_d = div_cnt_q + CW'(1);
    end

    // Commit consumes the old pending buffer before a same-cycle load refills it.
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_flag_d  = pend_flag_q;
    if (boundary && pend_flag_q) begin
      disp_val_d   = pend_val_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
      pend_flag_d  = 1'b0;
    end
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_mask;
      pend_blank_d = blank_mask;
      pend_flag_d  = 1'b1;
    end

    seg_d = 8'h00;
    an_d  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (en && (idx_q == IW'(i))) begin
        seg_d   = digit_seg[i];
        an_d[i] = 1'b1;
      end
    end

    // Two-stage delay lines frame_done up with an_out moving to digit 0.
    fd_arm_d     = boundary;
    frame_done_d = fd_arm_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_flag_q  <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      seg_q        <= 8'h00;
      an_q         <= '0;
      fd_arm_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_flag_q  <= pend_flag_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      fd_arm_q     <= fd_arm_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = frame_done_q;
  assign pending    = pend_flag_q;

endmodule

// File: tb/tb_seg_scan_hex.sv
// Directed bench for seg_scan_hex with DIGITS=4, SCAN_DIV=4 (16-cycle frames).
module tb_seg_scan_hex;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] value;
  logic [3:0]  dp_mask, blank_mask;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done, pending;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  seg_scan_hex #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
    .dp_mask(dp_mask), .blank_mask(blank_mask), .seg_out(seg_out),
    .an_out(an_out), .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d got=%h exp=%h", tag, edge_n, got, exp);
    end
    $display("chk %-12s edge=%0d got=%h exp=%h", tag, edge_n, got, exp);
  endtask

  // Advance to 1 time unit past rising edge number n (counted from reset release).
  task automatic go(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an_e, input logic [7:0] seg_e);
    chk({tag, "_an"}, 16'(an_out), 16'(an_e));
    chk({tag, "_seg"}, 16'(seg_out), 16'(seg_e));
  endtask

  initial begin
    logic [7:0] zero_hi;
`ifdef SEG_SCAN_LZ_EN
    zero_hi = 8'h00;
`else
    zero_hi = 8'hFC;
`endif
    rst = 1'b1; en = 1'b1; load = 1'b0;
    value = '0; dp_mask = '0; blank_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 4'b0000, 8'h00);
    chk("reset_pend", 16'(pending), 16'd0);
    chk("reset_fd", 16'(frame_done), 16'd0);

    // Release reset with a load of 1234; first boundary is edge 16.
    rst = 1'b0; load = 1'b1; value = 16'h1234;
    go(1);
    load = 1'b0;
    chk("pend_1234", 16'(pending), 16'd1);
    go(2);
    chk_out("pre_commit", 4'b0001, 8'hFC);
    go(16);
    chk("fd_before", 16'(frame_done), 16'd0);
    chk("pend_clear", 16'(pending), 16'd0);
    go(17);
    chk_out("scan_d0", 4'b0001, 8'h66);
    chk("fd_pulse", 16'(frame_done), 16'd1);
    go(18);
    chk("fd_low", 16'(frame_done), 16'd0);
    go(20);
    chk_out("d0_held", 4'b0001, 8'h66);
    go(21);
    chk_out("scan_d1", 4'b0010, 8'hF2);
    go(25);
    chk_out("scan_d2", 4'b0100, 8'hDA);
    go(29);
    chk_out("scan_d3", 4'b1000, 8'h60);
    go(32);
    chk("fd_pre32", 16'(frame_done), 16'd0);
    go(33);
    chk("fd_frame2", 16'(frame_done), 16'd1);

    // Mid-frame load: old digits continue until the boundary at edge 48.
    go(34);
    load = 1'b1; value = 16'hABCD;
    go(35);
    load = 1'b0;
    chk("pend_abcd", 16'(pending), 16'd1);
    chk_out("old_digit", 4'b0001, 8'h66);
    go(48);
    chk_out("still_old", 4'b1000, 8'h60);
    go(49);
    chk_out("new_d0", 4'b0001, 8'h7A);
    chk("pend_done", 16'(pending), 16'd0);

    // Two loads within one frame: the second wins at edge 64.
    go(50);
    load = 1'b1; value = 16'h1111;
    go(51);
    value = 16'h2222;
    go(52);
    load = 1'b0;
    chk("pend_two", 16'(pending), 16'd1);
    go(65);
    chk_out("last_wins", 4'b0001, 8'hDA);

    // Masks, committed at edge 80.
    go(66);
    load = 1'b1; value = 16'h8888; dp_mask = 4'b0010; blank_mask = 4'b0100;
    go(67);
    load = 1'b0; dp_mask = '0; blank_mask = '0;
    go(81);
    chk_out("mask_d0", 4'b0001, 8'hFE);
    go(85);
    chk_out("mask_dp1", 4'b0010, 8'hFF);
    go(89);
    chk_out("mask_blank2", 4'b0100, 8'h00);
    go(93);
    chk_out("mask_d3", 4'b1000, 8'hFE);

    // Pause mid-digit-3 for 10 edges, then resume with the remaining count.
    go(94);
    en = 1'b0;
    go(95);
    chk_out("en_off", 4'b0000, 8'h00);
    go(104);
    chk_out("en_off_end", 4'b0000, 8'h00);
    chk("en_off_fd", 16'(frame_done), 16'd0);
    en = 1'b1;
    go(105);
    chk_out("resume_d3", 4'b1000, 8'hFE);
    go(106);
    chk_out("resume_d3b", 4'b1000, 8'hFE);
    go(107);
    chk_out("resume_d0", 4'b0001, 8'hFE);
    chk("resume_fd", 16'(frame_done), 16'd1);

    // Leading zeros: value 0050 committed at edge 122.
    load = 1'b1; value = 16'h0050;
    go(108);
    load = 1'b0;
    go(123);
    chk_out("lz_d0", 4'b0001, 8'hFC);
    go(127);
    chk_out("lz_d1", 4'b0010, 8'hB6);
    go(131);
    chk_out("lz_d2", 4'b0100, zero_hi);
    go(135);
    chk_out("lz_d3", 4'b1000, zero_hi);

    // Reset mid-frame with a load pending.
    go(136);
    load = 1'b1; value = 16'h1234;
    go(137);
    load = 1'b0;
    chk("pend_prerst", 16'(pending), 16'd1);
    rst = 1'b1;
    go(138);
    chk_out("midrst", 4'b0000, 8'h00);
    chk("midrst_pend", 16'(pending), 16'd0);
    chk("midrst_fd", 16'(frame_done), 16'd0);
    rst = 1'b0;
    go(140);
    chk_out("post_rst", 4'b0001, 8'hFC);
    chk("post_rst_pend", 16'(pending), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
